// File: rtl/array_stream_reader_pkg.sv
//------------------------------------------------------------------------------
// array_stream_pkg : shared types for the array stream reader
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package array_stream_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_e;

endpackage

`default_nettype wire

// File: rtl/array_stream_reader_if.sv
//------------------------------------------------------------------------------
// array_stream_reader_if : write port, scan control and output stream bundle
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface array_stream_reader_if #(
   parameter int DSIZE = 32,
   parameter int DEPTH = 32
);
   localparam int AW = $clog2(DEPTH);

   logic             wr_en;
   logic [AW-1:0]    wr_addr;
   logic [DSIZE-1:0] wr_data;
   logic             start;
   logic             clr_on_read;
   logic             busy;
   logic             done;
   logic             out_valid;
   logic             out_ready;
   logic [DSIZE-1:0] out_data;
   logic [AW-1:0]    out_index;
   logic             out_last;

   modport master (
      output wr_en, wr_addr, wr_data, start, clr_on_read, out_ready,
      input  busy, done, out_valid, out_data, out_index, out_last
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, start, clr_on_read, out_ready,
      output busy, done, out_valid, out_data, out_index, out_last
   );

endinterface

`default_nettype wire

// File: rtl/array_stream_reader_regfile.sv
//------------------------------------------------------------------------------
// array_regfile : DEPTH x DSIZE storage with write port, clear port and a
//                 read that bypasses a same-cycle write to the read index
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module array_regfile #(
   parameter int DSIZE = 32,
   parameter int DEPTH = 32,
   parameter int AW    = $clog2(DEPTH)
) (
   input  wire logic             clk,
   input  wire logic             rst_n,
   input  wire logic             i_wr_en,
   input  wire logic [AW-1:0]    i_wr_addr,
   input  wire logic [DSIZE-1:0] i_wr_data,
   input  wire logic             i_clr_en,
   input  wire logic [AW-1:0]    i_clr_idx,
   input  wire logic [AW-1:0]    i_rd_idx,
   output logic      [DSIZE-1:0] o_rd_data
);

   logic [DSIZE-1:0] r_mem [DEPTH];

   // A write to the entry being cleared wins over the clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (i_wr_en && (i_wr_addr == AW'(i))) begin
               r_mem[i] <= i_wr_data;
            end else if (i_clr_en && (i_clr_idx == AW'(i))) begin
               r_mem[i] <= '0;
            end
         end
      end
   end

   always_comb begin
      o_rd_data = r_mem[i_rd_idx];
      if (i_wr_en && (i_wr_addr == i_rd_idx)) begin
         o_rd_data = i_wr_data;
      end
   end

endmodule

`default_nettype wire

// File: rtl/array_stream_reader.sv
//------------------------------------------------------------------------------
// array_stream_reader : streams every array entry in index order on start,
//                       with optional clear-on-read
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module array_stream_reader
   import array_stream_pkg::*;
#(
   parameter int DSIZE = 32,
   parameter int DEPTH = 32
) (
   input wire logic             clock,
   input wire logic             rst_n,
   array_stream_reader_if.slave bus
);

   localparam int            AW     = $clog2(DEPTH);
   localparam logic [AW-1:0] C_LAST = AW'(DEPTH - 1);

   state_e           r_state;
   logic             r_valid;
   logic             r_done;
   logic             r_clr;
   logic [AW-1:0]    r_index;
   logic [DSIZE-1:0] r_data;

   state_e           w_state_nx;
   logic             w_valid_nx;
   logic             w_done_nx;
   logic             w_clr_nx;
   logic [AW-1:0]    w_index_nx;
   logic             w_load;
   logic [AW-1:0]    w_rd_idx;
   logic             w_clr_en;
   logic             w_hs;
   logic [DSIZE-1:0] w_rd_data;

   array_regfile #(
      .DSIZE (DSIZE),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_regfile (
      .clk       (clock),
      .rst_n     (rst_n),
      .i_wr_en   (bus.wr_en),
      .i_wr_addr (bus.wr_addr),
      .i_wr_data (bus.wr_data),
      .i_clr_en  (w_clr_en),
      .i_clr_idx (r_index),
      .i_rd_idx  (w_rd_idx),
      .o_rd_data (w_rd_data)
   );

   assign w_hs = r_valid && bus.out_ready;

   always_comb begin
      w_state_nx = r_state;
      w_valid_nx = r_valid;
      w_done_nx  = 1'b0;
      w_clr_nx   = r_clr;
      w_index_nx = r_index;
      w_load     = 1'b0;
      w_rd_idx   = r_index + AW'(1);
      w_clr_en   = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.start) begin
               w_state_nx = SCAN;
               w_valid_nx = 1'b1;
               w_clr_nx   = bus.clr_on_read;
               w_index_nx = '0;
               w_rd_idx   = '0;
               w_load     = 1'b1;
            end
         end
         SCAN: begin
            if (w_hs) begin
               w_clr_en = r_clr;
               if (r_index == C_LAST) begin
                  w_state_nx = IDLE;
                  w_valid_nx = 1'b0;
                  w_done_nx  = 1'b1;
               end else begin
                  w_index_nx = r_index + AW'(1);
                  w_load     = 1'b1;
               end
            end
         end
         default: w_state_nx = IDLE;
      endcase
   end

   // Data/index only move on a load, so a stalled beat stays frozen.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_valid <= 1'b0;
         r_done  <= 1'b0;
         r_clr   <= 1'b0;
         r_index <= '0;
         r_data  <= '0;
      end else begin
         r_state <= w_state_nx;
         r_valid <= w_valid_nx;
         r_done  <= w_done_nx;
         r_clr   <= w_clr_nx;
         r_index <= w_index_nx;
         if (w_load) begin
            r_data <= w_rd_data;
         end
      end
   end

   assign bus.busy      = (r_state == SCAN);
   assign bus.done      = r_done;
   assign bus.out_valid = r_valid;
   assign bus.out_data  = r_data;
   assign bus.out_index = r_index;
   assign bus.out_last  = r_valid && (r_index == C_LAST);

endmodule

`default_nettype wire

// File: tb/tb_array_stream_reader.sv
//------------------------------------------------------------------------------
// tb_array_stream_reader : directed and randomized scans against a
//                          beat-level reference model of the array stream
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_array_stream_reader;

   localparam int DSIZE = 32;
   localparam int DEPTH = 32;
   localparam int AW    = $clog2(DEPTH);

   logic clock;
   logic rst_n;
   int   n_cmp = 0;
   int   n_err = 0;

   array_stream_reader_if #(.DSIZE(DSIZE), .DEPTH(DEPTH)) bus ();

   array_stream_reader #(.DSIZE(DSIZE), .DEPTH(DEPTH)) dut (
      .clock (clock),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Reference model: array contents plus the beat currently presented.
   logic [DSIZE-1:0] m_arr [DEPTH];
   logic             m_busy, m_valid, m_done, m_clr;
   int               m_idx;
   logic [DSIZE-1:0] m_data;

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) m_arr[i] = '0;
      m_busy = 0; m_valid = 0; m_done = 0; m_clr = 0; m_idx = 0; m_data = '0;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("busy",      32'(bus.busy),      32'(m_busy));
      chk("done",      32'(bus.done),      32'(m_done));
      chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
      chk("out_data",  bus.out_data,       m_data);
      chk("out_index", 32'(bus.out_index), 32'(m_idx));
      chk("out_last",  32'(bus.out_last),  32'(m_valid && (m_idx == DEPTH - 1)));
   endtask

   task automatic step(input logic we, input int wa, input logic [DSIZE-1:0] wd,
                       input logic st, input logic clr, input logic rdy);
      logic hs;
      @(negedge clock);
      bus.wr_en       = we;
      bus.wr_addr     = AW'(wa);
      bus.wr_data     = wd;
      bus.start       = st;
      bus.clr_on_read = clr;
      bus.out_ready   = rdy;
      hs     = m_valid && rdy;
      m_done = 0;
      if (hs && m_clr) m_arr[m_idx] = '0;
      if (we && wa < DEPTH) m_arr[wa] = wd;
      if (!m_busy) begin
         if (st) begin
            m_busy = 1; m_valid = 1; m_clr = clr; m_idx = 0; m_data = m_arr[0];
         end
      end else if (hs) begin
         if (m_idx == DEPTH - 1) begin
            m_busy = 0; m_valid = 0; m_done = 1;
         end else begin
            m_idx  = m_idx + 1;
            m_data = m_arr[m_idx];
         end
      end
      @(posedge clock);
      #1;
      check_all();
   endtask

   // rmode: 0 ready high, 1 ready 1,0,0,1 pattern, 2 random ready + stray starts
   // wmode: 0 none, 1 random writes, 2 stall/late-write case, 3 write on clear
   task automatic run_scan(input logic clr, input int rmode, input int wmode);
      int   beats = 0;
      bit   fin = 0, stalled5 = 0, wrote3 = 0;
      logic we, st, rdy;
      int   wa;
      logic [DSIZE-1:0] wd;
      for (int c = 0; c < 400 && !fin; c++) begin
         st = (c == 0); we = 0; wa = 0; wd = '0;
         case (rmode)
            0:       rdy = 1;
            1:       rdy = (c % 4 == 0) || (c % 4 == 3);
            default: begin
               rdy = 1'($urandom % 2);
               if (c > 0 && ($urandom % 4) == 0) st = 1;
            end
         endcase
         case (wmode)
            1: if (($urandom % 3) == 0) begin
                  we = 1; wa = int'($urandom % DEPTH); wd = $urandom;
               end
            2: if (m_valid && m_idx == 5 && !stalled5) begin
                  rdy = 0; we = 1; wa = 6; wd = 32'hDEADBEEF; stalled5 = 1;
               end else if (m_valid && m_idx == 8 && !wrote3) begin
                  we = 1; wa = 3; wd = 32'h12345678; wrote3 = 1;
               end
            3: if (m_valid && m_idx == 4 && rdy) begin
                  we = 1; wa = 4; wd = 32'hA5A5A5A5;
               end
            default: ;
         endcase
         if (bus.out_valid && rdy) beats++;
         step(we, wa, wd, st, clr, rdy);
         if (m_done) fin = 1;
      end
      chk("scan_done", 32'(fin), 32'd1);
      chk("beat_count", 32'(beats), 32'(DEPTH));
   endtask

   initial begin
      rst_n = 0;
      bus.wr_en = 0; bus.wr_addr = '0; bus.wr_data = '0;
      bus.start = 0; bus.clr_on_read = 0; bus.out_ready = 0;
      model_reset();
      repeat (3) @(posedge clock);
      #1;
      check_all();
      @(negedge clock);
      rst_n = 1;

      for (int i = 0; i < DEPTH; i++) step(1, i, DSIZE'(i) * 32'h01010101, 0, 0, 1);
      run_scan(0, 0, 0);
      run_scan(0, 1, 0);
      run_scan(0, 1, 2);
      run_scan(0, 0, 0);
      run_scan(1, 0, 0);
      run_scan(0, 0, 0);
      for (int i = 0; i < DEPTH; i++) step(1, i, $urandom, 0, 0, 1);
      run_scan(1, 0, 3);
      run_scan(0, 0, 0);

      // Reset in the middle of a scan.
      step(0, 0, '0, 1, 0, 1);
      for (int c = 0; c < 64 && m_idx < 10; c++) step(0, 0, '0, 0, 0, 1);
      @(negedge clock);
      #2;
      rst_n = 0;
      #1;
      model_reset();
      check_all();
      @(posedge clock);
      #1;
      check_all();
      @(negedge clock);
      rst_n = 1;
      step(0, 0, '0, 0, 0, 1);
      run_scan(0, 2, 0);

      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < 12; i++) step(1, int'($urandom % DEPTH), $urandom, 0, 0, 1);
         run_scan(1'($urandom % 2), 2, 1);
      end
      run_scan(0, 2, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/array_stream_reader.md
Name: array_stream_reader

Overview:
- Register array of DEPTH words of DSIZE bits; a simple write port fills it.
- On a start command the array is read back: every entry, in index order 0..DEPTH-1, streams out over a valid/ready interface.
- Optional clear-on-read zeroes each entry as it is handed off.
- This is the read-out side of the array-fill logic: software writers populate it, the stream drains it to downstream consumers.

Parameters:
- DSIZE, 32, data word width in bits.
- DEPTH, 32, number of array entries; must be >= 2.
- AW, $clog2(DEPTH), address/index width; derived, not overridden.

Ports:
- clock  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- wr_en  input  1  write strobe.
- wr_addr  input  AW  write index; values >= DEPTH are ignored.
- wr_data  input  DSIZE  write data.
- start  input  1  begin a scan; sampled only in IDLE.
- clr_on_read  input  1  sampled with start; latched for the whole scan.
- busy  output  1  high in SCAN.
- done  output  1  one-cycle pulse after the final handshake.
- out_valid  output  1  stream valid.
- out_ready  input  1  stream ready.
- out_data  output  DSIZE  entry value.
- out_index  output  AW  index of the entry on out_data.
- out_last  output  1  high with out_valid when out_index == DEPTH-1.

Behaviour:
- Reset (async, rst_n low): state IDLE, all array entries 0. Outputs busy, done, out_valid, out_last = 0; out_data = 0; out_index = 0. Reset mid-scan aborts immediately and emits no done.
- FSM states:
  - IDLE: start=1 -> SCAN. In that same cycle, out_data <= entry 0, out_index <= 0, out_valid <= 1 next cycle, and clr_on_read is latched. Start-to-first-valid latency is 1 cycle.
  - SCAN: a handshake is out_valid && out_ready. On a handshake with index k < DEPTH-1: load entry k+1 into out_data, set out_index = k+1, keep out_valid high. Throughput is one word per cycle.
  - SCAN, last entry: a handshake at k = DEPTH-1 -> out_valid <= 0, done <= 1 for one cycle, state -> IDLE.
  - Backpressure: while out_valid && !out_ready, out_data, out_index and out_last hold stable, even if the array entry is written meanwhile.
- out_data is registered. When loading entry j in a cycle where wr_en && wr_addr == j, out_data takes wr_data (write bypass), so the stream always reflects the latest value.
- Clear-on-read: on the handshake of entry k, entry k <= 0. If wr_en hits k in the same cycle, the write wins and the entry keeps wr_data.
- Writes are accepted in every state. Writes to already-streamed entries are not re-sent in the current scan.
- start while busy is ignored; no queueing.
- start asserted in the cycle done pulses: FSM is back in IDLE that cycle, so the new scan starts and out_valid rises on the following cycle.
- No combinational path from out_ready to out_valid.

Decomposition:
- Package array_stream_pkg holds the state enum typedef (IDLE, SCAN).
- One sub-module, array_regfile, is natural: DEPTH x DSIZE storage with async reset, write port, clear-index port and a bypassed read. The FSM and stream register stay in the top module.

Test Plan:
- Write entry[i] = i*0x01010101 for all i; pulse start with clr_on_read=0; hold out_ready=1 -> 32 consecutive beats with indices 0..31 and matching data; out_last on beat 31; done one cycle later; array unchanged.
- Same fill; out_ready toggles 1,0,0,1 -> each beat holds stable while ready is low; total 32 beats, no duplicates or drops.
- Start with clr_on_read=1, full stream, then a second scan -> second scan returns all 0x00000000.
- During a stalled beat 5, write wr_addr=6 with 0xDEADBEEF -> beat 6 shows 0xDEADBEEF. Write wr_addr=3 with 0x12345678 -> not re-sent; a later scan shows it.
- With clr_on_read=1, write wr_addr=4 with 0xA5A5A5A5 in the same cycle as the beat 4 handshake -> entry 4 reads back 0xA5A5A5A5 in the next scan.
- Deassert rst_n at beat 10 -> all outputs 0 immediately, no done; after release, a scan returns all 0s. Pulse start while busy -> ignored.
